// File: rtl/user_bram_pkg.sv
// user_bram_pkg: shared FSM states, default window base and index-width helper
package user_bram_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, ACC, ACK} state_t;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h3800_0000;
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/user_bram_sram.sv
// user_bram_sram: single-port synchronous RAM with byte write mask and registered output
module user_bram_sram
    import user_bram_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    sel,
    input  logic [AW-1:0] adr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (en) begin
            if (we)
                for (int i = 0; i < 4; i++)
                    if (sel[i]) mem[adr][8*i +: 8] <= din[8*i +: 8];
            dout <= mem[adr];
        end
endmodule

// File: rtl/user_bram_ctrl.sv
// user_bram_ctrl: Wishbone slave with programmable wait states in front of an on-chip SRAM
module user_bram_ctrl
    import user_bram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          DEPTH     = 1024,
    parameter int          DELAYS    = 10
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o
);
    localparam int AW = idx_w(DEPTH);
    localparam logic [7:0] DLY = 8'(DELAYS);
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d, rd_data;
    logic [3:0] sel_q, sel_d;
    logic we_q, we_d, hit, unused_ok;
    assign unused_ok = ^wbs_adr_i[1:0];
    assign hit = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        adr_d = adr_q;
        dat_d = dat_q;
        sel_d = sel_q;
        we_d = we_q;
        case (state_q)
            IDLE:
                if (hit) begin
                    state_d = (DLY == 8'd0) ? ACC : WAIT;
                    cnt_d = DLY;
                    adr_d = wbs_adr_i[AW+1:2];
                    dat_d = wbs_dat_i;
                    sel_d = wbs_sel_i;
                    we_d = wbs_we_i;
                end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                state_d = !wbs_cyc_i ? IDLE : (cnt_q == 8'd1) ? ACC : WAIT;
            end
            ACC: state_d = ACK;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i)
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            sel_q <= '0;
            we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            adr_q <= adr_d;
            dat_q <= dat_d;
            sel_q <= sel_d;
            we_q <= we_d;
        end
    user_bram_sram #(.DEPTH(DEPTH)) u_sram (
        .clk (wb_clk_i),
        .en  (state_q == ACC),
        .we  (we_q),
        .sel (sel_q),
        .adr (adr_q),
        .din (dat_q),
        .dout(rd_data)
    );
    assign wbs_ack_o = (state_q == ACK) && wbs_cyc_i && wbs_stb_i;
    assign wbs_dat_o = (wbs_ack_o && !we_q) ? rd_data : 32'd0;
    assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_user_bram_ctrl.sv
// tb_user_bram_ctrl: two windows (DELAYS=10 at 0x3800_0000, DELAYS=0 at 0x3800_1000) on one bus vs a word-array model
module tb_user_bram_ctrl;
    localparam logic [31:0] BA = 32'h3800_0000;
    localparam logic [31:0] BB = 32'h3800_1000;
    logic clk = 1'b0, rst = 1'b1;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0] sel = 4'h0;
    logic [31:0] adr = 32'h0, wdat = 32'h0;
    logic ack_a, ack_b, busy_a, busy_b, ack;
    logic [31:0] dat_a, dat_b, rdat, rd;
    logic [31:0] mem_a [1024];
    logic [31:0] mem_b [1024];
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    assign ack = ack_a | ack_b;
    assign rdat = dat_a | dat_b;
    user_bram_ctrl #(.BASE_ADDR(BA), .DEPTH(1024), .DELAYS(10)) u_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_a),
        .wbs_dat_o(dat_a), .busy_o(busy_a)
    );
    user_bram_ctrl #(.BASE_ADDR(BB), .DEPTH(1024), .DELAYS(0)) u_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_b),
        .wbs_dat_o(dat_b), .busy_o(busy_b)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] r);
        int lat;
        logic [31:0] e;
        e = a[12] ? mem_b[a[11:2]] : mem_a[a[11:2]];
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        lat = -1;
        r = 32'h0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack) begin
                lat = n;
                r = rdat;
                break;
            end
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        check({tag, "_lat"}, 32'(lat), a[12] ? 32'd2 : 32'd12);
        if (!w) check({tag, "_rd"}, r, e);
        else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) e[8*b +: 8] = d[8*b +: 8];
            if (a[12]) mem_b[a[11:2]] = e;
            else mem_a[a[11:2]] = e;
        end
    endtask
    initial begin
        int idx;
        logic [31:0] a;
        repeat (3) @(posedge clk);
        check("rst_out", {28'h0, ack, busy_a, busy_b, |rdat}, 32'h0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            idx = (i == 8) ? 1023 : i;
            xfer("init_a", 1'b1, BA | 32'(idx << 2), 4'hF, $urandom, rd);
            xfer("init_b", 1'b1, BB | 32'(idx << 2), 4'hF, $urandom, rd);
        end
        xfer("db_wr", 1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, rd);
        xfer("db_rd", 1'b0, 32'h3800_0010, 4'hF, 32'h0, rd);
        check("db_const", rd, 32'hDEAD_BEEF);
        xfer("bm_wr0", 1'b1, BA + 32'h14, 4'hF, 32'h1122_3344, rd);
        xfer("bm_wr1", 1'b1, BA + 32'h14, 4'b0101, 32'hAABB_CCDD, rd);
        xfer("bm_rd", 1'b0, BA + 32'h14, 4'h0, 32'h0, rd);
        check("bm_const", rd, 32'h11BB_33DD);
        xfer("sel0_wr", 1'b1, BB + 32'h8, 4'h0, 32'h5555_5555, rd);
        xfer("sel0_rd", 1'b0, BB + 32'h8, 4'hF, 32'h0, rd);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BB + 32'hC;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            check("b2b_ack", 32'(ack), (n % 3 == 2) ? 32'd1 : 32'd0);
            check("b2b_dat", rdat, (n % 3 == 2) ? mem_b[3] : 32'h0);
        end
        @(posedge clk); #1;
        adr = 32'h3000_0000;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("miss", {29'h0, ack, busy_a, busy_b}, 32'h0);
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        xfer("ab_pre", 1'b1, BA + 32'h20, 4'hF, 32'hCAFE_F00D, rd);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BA + 32'h20; wdat = 32'h1234_5678;
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        for (int n = 5; n < 21; n++) begin
            @(negedge clk);
            check("ab_noack", 32'(ack), 32'd0);
            check("ab_busy", 32'(busy_a), (n == 5) ? 32'd1 : 32'd0);
        end
        xfer("ab_rd", 1'b0, BA + 32'h20, 4'hF, 32'h0, rd);
        check("ab_const", rd, 32'hCAFE_F00D);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BA + 32'h4;
        repeat (4) @(negedge clk);
        check("rs_busy_pre", 32'(busy_a), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rs_async", {28'h0, ack, busy_a, busy_b, |rdat}, 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk) rst = 1'b0;
        xfer("rs_next", 1'b0, BA + 32'h4, 4'hF, 32'h0, rd);
        for (int i = 0; i < 24; i++) begin
            idx = $urandom_range(0, 8);
            if (idx == 8) idx = 1023;
            a = ($urandom_range(0, 1) ? BB : BA) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            xfer("rnd", 1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, rd);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
